zet_wb_bus_watchdog: RTL

Wishbone register slice plus bus watchdog placed directly downstream of the CPU wrapper's slave 0 port, in front of the memory/IO fabric. It registers each CPU request and forwards it to the downstream slave. It returns the slave's ack and data to the CPU one cycle later. If the slave never acks, it terminates the cycle itself with open-bus data, so a missing or hung peripheral cannot stall the Zet CPU.

---
 rtl/zet_wb_pkg.sv | 15 +
 rtl/zet_wb_wdt_counter.sv | 28 ++
 rtl/zet_wb_bus_watchdog.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/zet_wb_pkg.sv
// Shared Wishbone constants and watchdog FSM state type for the Zet bus slices.
package zet_wb_pkg;

  localparam int WB_DW = 16;
  localparam int WB_AW = 20;

  localparam logic [WB_DW-1:0] OPEN_BUS_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } wdt_state_e;

endpackage

// File: rtl/zet_wb_wdt_counter.sv
// Loadable cycle counter with terminal-count flag at TIMEOUT-1; holds at terminal count.
module zet_wb_wdt_counter #(
  parameter  int TIMEOUT = 255,
  localparam int CW      = $clog2(TIMEOUT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ld_i,
  input  logic [CW-1:0] ld_val_i,
  input  logic          en_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q;

  assign tc_o = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/zet_wb_bus_watchdog.sv
// Wishbone register slice with bus watchdog: forwards CPU requests and forces open-bus
// termination when the slave does not ack. Optional error log: ZET_WB_WDT_ERRLOG_EN.
module zet_wb_bus_watchdog
  import zet_wb_pkg::*;
#(
  parameter int               TIMEOUT       = 255,
  parameter logic [WB_DW-1:0] OPEN_BUS_DATA = OPEN_BUS_DEFAULT
) (
  input  logic             cpu_clk_i,
  input  logic             cpu_rst_i,
  input  logic [WB_DW-1:0] m_dat_i,
  output logic [WB_DW-1:0] m_dat_o,
  input  logic [WB_AW-1:0] m_adr_i,
  input  logic [1:0]       m_sel_i,
  input  logic             m_we_i,
  input  logic             m_cyc_i,
  input  logic             m_stb_i,
  output logic             m_ack_o,
  input  logic [WB_DW-1:0] s_dat_i,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_AW-1:0] s_adr_o,
  output logic [1:0]       s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic             s_ack_i,
  output logic             timeout_o,
  output logic [7:0]       err_cnt_o
`ifdef ZET_WB_WDT_ERRLOG_EN
  ,
  output logic [WB_AW-1:0] err_adr_o,
  output logic             err_we_o
`endif
);

  localparam int CW = $clog2(TIMEOUT);

  wdt_state_e       state_q, state_d;
  logic [WB_DW-1:0] m_dat_q, m_dat_d;
  logic [WB_DW-1:0] s_dat_q, s_dat_d;
  logic [WB_AW-1:0] s_adr_q, s_adr_d;
  logic [1:0]       s_sel_q, s_sel_d;
  logic             s_we_q, s_we_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             cnt_ld, cnt_tc;

`ifdef ZET_WB_WDT_ERRLOG_EN
  logic [WB_AW-1:0] err_adr_q, err_adr_d;
  logic             err_we_q, err_we_d;
`endif

  zet_wb_wdt_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk_i    (cpu_clk_i),
    .rst_ni   (cpu_rst_i),
    .ld_i     (cnt_ld),
    .ld_val_i ({CW{1'b0}}),
    .en_i     (state_q == BUSY),
    .tc_o     (cnt_tc)
  );

  always_comb begin
    state_d   = state_q;
    m_dat_d   = m_dat_q;
    s_dat_d   = s_dat_q;
    s_adr_d   = s_adr_q;
    s_sel_d   = s_sel_q;
    s_we_d    = s_we_q;
    timeout_d = 1'b0;
    err_cnt_d = err_cnt_q;
    cnt_ld    = 1'b0;
`ifdef ZET_WB_WDT_ERRLOG_EN
    err_adr_d = err_adr_q;
    err_we_d  = err_we_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          s_dat_d = m_dat_i;
          s_adr_d = m_adr_i;
          s_sel_d = m_sel_i;
          s_we_d  = m_we_i;
          cnt_ld  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A dropped cyc means nobody is waiting for the answer, so it overrides ack/timeout.
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else if (s_ack_i) begin
          m_dat_d = s_dat_i;
          state_d = ACK;
        end else if (cnt_tc) begin
          m_dat_d   = OPEN_BUS_DATA;
          timeout_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
`ifdef ZET_WB_WDT_ERRLOG_EN
          err_adr_d = s_adr_q;
          err_we_d  = s_we_q;
`endif
          state_d   = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_i or negedge cpu_rst_i) begin
    if (!cpu_rst_i) begin
      state_q   <= IDLE;
      m_dat_q   <= '0;
      s_dat_q   <= '0;
      s_adr_q   <= '0;
      s_sel_q   <= '0;
      s_we_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      m_dat_q   <= m_dat_d;
      s_dat_q   <= s_dat_d;
      s_adr_q   <= s_adr_d;
      s_sel_q   <= s_sel_d;
      s_we_q    <= s_we_d;
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

`ifdef ZET_WB_WDT_ERRLOG_EN
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_i) begin
    if (!cpu_rst_i) begin
      err_adr_q <= '0;
      err_we_q  <= 1'b0;
    end else begin
      err_adr_q <= err_adr_d;
      err_we_q  <= err_we_d;
    end
  end

  assign err_adr_o = err_adr_q;
  assign err_we_o  = err_we_q;
`endif

  assign m_dat_o   = m_dat_q;
  assign m_ack_o   = (state_q == ACK);
  assign s_dat_o   = s_dat_q;
  assign s_adr_o   = s_adr_q;
  assign s_sel_o   = s_sel_q;
  assign s_we_o    = s_we_q;
  assign s_cyc_o   = (state_q == BUSY);
  assign s_stb_o   = (state_q == BUSY);
  assign timeout_o = timeout_q;
  assign err_cnt_o = err_cnt_q;

endmodule
